// File: rtl/fnd_scan_decoder_if.sv
// Observed seven-segment scan bus plus the decoded digit outputs of fnd_scan_decoder.
interface fnd_scan_decoder_if;
  logic [6:0] iSeg;
  logic       iDigitSel;
  logic [3:0] oDigit_1;
  logic [3:0] oDigit_2;
  logic       oValid;
  logic       oErr;

  modport master (
    output iSeg,
    output iDigitSel,
    input  oDigit_1,
    input  oDigit_2,
    input  oValid,
    input  oErr
  );

  modport slave (
    input  iSeg,
    input  iDigitSel,
    output oDigit_1,
    output oDigit_2,
    output oValid,
    output oErr
  );
endinterface

// File: rtl/fnd_scan_decoder.sv
// Snoops a two-digit multiplexed seven-segment display and recovers the shown hex digits.
// Define FND_DEC_INV_SEG_EN for common-anode (active-low) segment buses.
module fnd_scan_decoder #(
  parameter int SETTLE_CYCLES = 4
) (
  input logic iCLK,
  input logic iRST_N,
  fnd_scan_decoder_if.slave bus
);

  typedef enum logic [1:0] {WAIT, SETTLE, SAMPLE} stateT;

  localparam logic [7:0] LastCnt = 8'(SETTLE_CYCLES - 1);

  stateT      state;
  logic [7:0] settleCnt;
  logic       selPrev;
  logic [6:0] segPrev;
  logic       target;
  logic       sampleFire;
  logic       sampleTarget;
  logic [6:0] sampleSeg;
  logic       capt1;
  logic       capt2;

  logic [6:0] segEff;
  logic       selEdge;
  logic       segStable;
  logic       decValid;
  logic [3:0] decValue;

`ifdef FND_DEC_INV_SEG_EN
  assign segEff = ~bus.iSeg;
`else
  assign segEff = bus.iSeg;
`endif

  assign selEdge   = (bus.iDigitSel != selPrev);
  assign segStable = (segEff == segPrev);

  always_comb begin
    decValid = 1'b1;
    decValue = 4'h0;
    case (sampleSeg)
      7'h3F: decValue = 4'h0;
      7'h06: decValue = 4'h1;
      7'h5B: decValue = 4'h2;
      7'h4F: decValue = 4'h3;
      7'h66: decValue = 4'h4;
      7'h6D: decValue = 4'h5;
      7'h7D: decValue = 4'h6;
      7'h07: decValue = 4'h7;
      7'h7F: decValue = 4'h8;
      7'h6F: decValue = 4'h9;
      7'h77: decValue = 4'hA;
      7'h7C: decValue = 4'hB;
      7'h39: decValue = 4'hC;
      7'h5E: decValue = 4'hD;
      7'h79: decValue = 4'hE;
      7'h71: decValue = 4'hF;
      default: decValid = 1'b0;
    endcase
  end

  // The select register is frozen during SAMPLE so an edge arriving then is seen in WAIT.
  // The sample is decoded one clock after SAMPLE, which is where the outputs change.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state        <= WAIT;
      settleCnt    <= 8'd0;
      selPrev      <= 1'b0;
      segPrev      <= 7'h00;
      target       <= 1'b0;
      sampleFire   <= 1'b0;
      sampleTarget <= 1'b0;
      sampleSeg    <= 7'h00;
      capt1        <= 1'b0;
      capt2        <= 1'b0;
      bus.oDigit_1 <= 4'h0;
      bus.oDigit_2 <= 4'h0;
      bus.oValid   <= 1'b0;
      bus.oErr     <= 1'b0;
    end else begin
      segPrev    <= segEff;
      sampleFire <= 1'b0;
      bus.oValid <= 1'b0;
      bus.oErr   <= 1'b0;
      if (state != SAMPLE) selPrev <= bus.iDigitSel;

      case (state)
        WAIT: begin
          if (selEdge) begin
            state     <= SETTLE;
            settleCnt <= 8'd0;
            target    <= bus.iDigitSel;
          end
        end
        SETTLE: begin
          if (selEdge) begin
            settleCnt <= 8'd0;
            target    <= bus.iDigitSel;
          end else if (!segStable) begin
            settleCnt <= 8'd0;
          end else if (settleCnt == LastCnt) begin
            state     <= SAMPLE;
            settleCnt <= 8'd0;
          end else begin
            settleCnt <= settleCnt + 8'd1;
          end
        end
        SAMPLE: begin
          state        <= WAIT;
          sampleFire   <= 1'b1;
          sampleSeg    <= segPrev;
          sampleTarget <= target;
        end
        default: state <= WAIT;
      endcase

      if (sampleFire) begin
        if (!decValid) begin
          bus.oErr <= 1'b1;
        end else begin
          if (sampleTarget) bus.oDigit_2 <= decValue;
          else              bus.oDigit_1 <= decValue;
          if ((sampleTarget && capt1) || (!sampleTarget && capt2)) begin
            bus.oValid <= 1'b1;
            capt1      <= 1'b0;
            capt2      <= 1'b0;
          end else if (sampleTarget) begin
            capt2 <= 1'b1;
          end else begin
            capt1 <= 1'b1;
          end
        end
      end
    end
  end

endmodule
